scramble_line_scheduler: RTL and testbench



---
 rtl/scramble_line_scheduler.sv | 178 +++++++++++++++++
 tb/tb_scramble_line_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/scramble_line_scheduler.sv
// Pops one DRBG byte per active line during H-blank and presents it as the line's cut position.
// Latency: cut_position/line_index update one clock after the H-fall cycle; seed/reset pulses one clock after V rise.
// Backpressure: waits in FETCH for rand_byte_valid; a line start with no byte is counted as an underrun.
module scramble_line_scheduler #(
    parameter int DATA_WIDTH         = 8,
    parameter int LINE_CNT_WIDTH     = 10,
    parameter int MAX_FETCH_LINES    = 288,
    parameter int UNDERRUN_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          H,
    input  logic                          V,
    input  logic [DATA_WIDTH-1:0]         rand_byte,
    input  logic                          rand_byte_valid,
    output logic                          rand_byte_take,
    output logic                          next_seed,
    output logic                          consumer_reset_n,
    output logic [DATA_WIDTH-1:0]         cut_position,
    output logic                          cut_valid,
    output logic [LINE_CNT_WIDTH-1:0]     line_index,
    output logic                          underrun,
    output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count
);

    localparam int                FCNT_W    = $clog2(MAX_FETCH_LINES + 1);
    localparam logic [FCNT_W-1:0] FETCH_MAX = FCNT_W'(MAX_FETCH_LINES);

    typedef enum logic [1:0] {
        VBLANK  = 2'd0,
        WAIT_HB = 2'd1,
        FETCH   = 2'd2,
        READY   = 2'd3
    } state_t;

    state_t                          r_state,     w_state_nx;
    logic                            r_prev_h,    r_prev_v;
    logic [DATA_WIDTH-1:0]           r_pending,   w_pending_nx;
    logic [FCNT_W-1:0]               r_fetch_cnt, w_fetch_cnt_nx;
    logic                            r_first,     w_first_nx;
    logic                            r_take,      w_take_nx;
    logic                            r_seed,      w_seed_nx;
    logic                            r_crst_n,    w_crst_n_nx;
    logic [DATA_WIDTH-1:0]           r_cut,       w_cut_nx;
    logic                            r_cut_vld,   w_cut_vld_nx;
    logic [LINE_CNT_WIDTH-1:0]       r_line,      w_line_nx;
    logic                            r_underrun,  w_underrun_nx;
    logic [UNDERRUN_CNT_WIDTH-1:0]   r_ucnt,      w_ucnt_nx;

    logic w_h_rise, w_h_fall, w_v_rise, w_v_fall, w_line_start;

    assign w_h_rise     = H & ~r_prev_h;
    assign w_h_fall     = ~H & r_prev_h;
    assign w_v_rise     = V & ~r_prev_v;
    assign w_v_fall     = ~V & r_prev_v;
    assign w_line_start = w_h_fall & ~V;

    always_comb begin
        w_state_nx     = r_state;
        w_pending_nx   = r_pending;
        w_fetch_cnt_nx = r_fetch_cnt;
        w_first_nx     = r_first;
        w_take_nx      = 1'b0;
        w_seed_nx      = 1'b0;
        w_crst_n_nx    = 1'b1;
        w_cut_nx       = r_cut;
        w_cut_vld_nx   = r_cut_vld;
        w_line_nx      = r_line;
        w_underrun_nx  = 1'b0;
        w_ucnt_nx      = r_ucnt;

        if (w_v_rise) begin
            // Field start outranks any H edge or pop seen in the same cycle.
            w_seed_nx      = 1'b1;
            w_crst_n_nx    = 1'b0;
            w_cut_vld_nx   = 1'b0;
            w_line_nx      = '0;
            w_pending_nx   = '0;
            w_fetch_cnt_nx = '0;
            w_first_nx     = 1'b1;
            w_state_nx     = VBLANK;
        end else begin
            case (r_state)
                VBLANK: begin
                    if (w_v_fall) begin
                        w_first_nx     = 1'b1;
                        w_fetch_cnt_nx = '0;
                        w_state_nx     = WAIT_HB;
                    end
                end
                WAIT_HB: begin
                    if (w_line_start) begin
                        w_cut_vld_nx = 1'b1;
                    end else if (w_h_rise && (r_fetch_cnt < FETCH_MAX)) begin
                        w_fetch_cnt_nx = r_fetch_cnt + FCNT_W'(1);
                        w_state_nx     = FETCH;
                    end
                end
                FETCH: begin
                    // A line start beats a byte arriving in the same cycle: the fetch is abandoned.
                    if (w_line_start) begin
                        w_underrun_nx = 1'b1;
                        w_cut_vld_nx  = 1'b1;
                        if (r_ucnt != '1) begin
                            w_ucnt_nx = r_ucnt + UNDERRUN_CNT_WIDTH'(1);
                        end
                        w_state_nx = WAIT_HB;
                    end else if (rand_byte_valid) begin
                        w_take_nx    = 1'b1;
                        w_pending_nx = rand_byte;
                        w_state_nx   = READY;
                    end
                end
                READY: begin
                    if (w_line_start) begin
                        w_cut_nx     = r_pending;
                        w_cut_vld_nx = 1'b1;
                        w_state_nx   = WAIT_HB;
                    end
                end
                default: w_state_nx = VBLANK;
            endcase

            // The first line of a field keeps index 0; later lines count up and wrap.
            if (w_line_start && (r_state != VBLANK)) begin
                if (r_first) begin
                    w_first_nx = 1'b0;
                end else begin
                    w_line_nx = r_line + LINE_CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= VBLANK;
            r_prev_h    <= 1'b1;
            r_prev_v    <= 1'b1;
            r_pending   <= '0;
            r_fetch_cnt <= '0;
            r_first     <= 1'b1;
            r_take      <= 1'b0;
            r_seed      <= 1'b0;
            r_crst_n    <= 1'b1;
            r_cut       <= '0;
            r_cut_vld   <= 1'b0;
            r_line      <= '0;
            r_underrun  <= 1'b0;
            r_ucnt      <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_prev_h    <= H;
            r_prev_v    <= V;
            r_pending   <= w_pending_nx;
            r_fetch_cnt <= w_fetch_cnt_nx;
            r_first     <= w_first_nx;
            r_take      <= w_take_nx;
            r_seed      <= w_seed_nx;
            r_crst_n    <= w_crst_n_nx;
            r_cut       <= w_cut_nx;
            r_cut_vld   <= w_cut_vld_nx;
            r_line      <= w_line_nx;
            r_underrun  <= w_underrun_nx;
            r_ucnt      <= w_ucnt_nx;
        end
    end

    assign rand_byte_take   = r_take;
    assign next_seed        = r_seed;
    assign consumer_reset_n = r_crst_n;
    assign cut_position     = r_cut;
    assign cut_valid        = r_cut_vld;
    assign line_index       = r_line;
    assign underrun         = r_underrun;
    assign underrun_count   = r_ucnt;

endmodule

// File: tb/tb_scramble_line_scheduler.sv
// Bench for scramble_line_scheduler: line-level reference model (per-line byte/underrun outcome)
// driven by directed steps and randomized line timings.
module tb_scramble_line_scheduler;

    localparam int DW   = 8;
    localparam int LW   = 4;
    localparam int MAXF = 3;
    localparam int UW   = 3;
    localparam int UMAX = (1 << UW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          h, v, rv;
    logic [DW-1:0] rb;
    logic          take, seed, crst_n, cut_vld, und;
    logic [DW-1:0] cut;
    logic [LW-1:0] lidx;
    logic [UW-1:0] ucnt;

    always #5 clk = ~clk;

    scramble_line_scheduler #(
        .DATA_WIDTH         (DW),
        .LINE_CNT_WIDTH     (LW),
        .MAX_FETCH_LINES    (MAXF),
        .UNDERRUN_CNT_WIDTH (UW)
    ) dut (
        .clk              (clk),
        .reset_n          (rst_n),
        .H                (h),
        .V                (v),
        .rand_byte        (rb),
        .rand_byte_valid  (rv),
        .rand_byte_take   (take),
        .next_seed        (seed),
        .consumer_reset_n (crst_n),
        .cut_position     (cut),
        .cut_valid        (cut_vld),
        .line_index       (lidx),
        .underrun         (und),
        .underrun_count   (ucnt)
    );

    int            total = 0;
    int            bad   = 0;
    int            k     = 0;      // line number within current field
    logic [DW-1:0] exp_cut = '0;
    int            exp_ucnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_take"},  take,    0);
        chk({tag, "_seed"},  seed,    0);
        chk({tag, "_crstn"}, crst_n,  1);
        chk({tag, "_cut"},   cut,     0);
        chk({tag, "_cutv"},  cut_vld, 0);
        chk({tag, "_lidx"},  lidx,    0);
        chk({tag, "_und"},   und,     0);
        chk({tag, "_ucnt"},  ucnt,    0);
    endtask

    // Vertical blanking of n cycles (rise=1: V rises on the first one), then V falls with H low.
    task automatic field_gap(input int n, input bit rise);
        for (int i = 0; i < n; i++) begin
            h = 1'b1; v = 1'b1; rv = 1'($urandom_range(0, 1)); rb = 8'($urandom);
            tick();
            chk("vb_take", take, 0);
            if (rise && i == 0) begin
                chk("vr_seed",  seed,    1);
                chk("vr_crstn", crst_n,  0);
                chk("vr_cutv",  cut_vld, 0);
                chk("vr_lidx",  lidx,    0);
            end else begin
                chk("vb_seed",  seed,   0);
                chk("vb_crstn", crst_n, 1);
            end
        end
        h = 1'b0; v = 1'b1; rv = 1'b0;
        tick();
        chk("vbhf_und",  und,  0);
        chk("vbhf_lidx", lidx, 0);
        h = 1'b0; v = 1'b0;
        tick();
        chk("vf_cutv", cut_vld, 0);
        chk("vf_seed", seed,    0);
        tick();
        chk("vf_take", take, 0);
        k = 0;
    endtask

    // One line: B blank cycles (valid from blank offset d), then A active cycles.
    // vr >= 0: V rises at blank offset vr and the field ends there.
    task automatic run_line(input int B, input int A, input int d, input logic [DW-1:0] b, input int vr);
        bit fetch, pops, unr;
        int p;
        fetch = (k < MAXF);
        p     = (d < 1) ? 1 : d;
        pops  = fetch && (p < B) && (vr < 0 || p < vr);
        unr   = fetch && !pops;
        for (int i = 0; i < B; i++) begin
            h = 1'b1; v = (vr >= 0 && i >= vr); rv = (i >= d) || take; rb = b;
            tick();
            chk("blank_take", take, (pops && i == p));
            if (vr >= 0 && i == vr) begin
                chk("vr_seed",  seed,    1);
                chk("vr_crstn", crst_n,  0);
                chk("vr_cutv",  cut_vld, 0);
                chk("vr_lidx",  lidx,    0);
            end else begin
                chk("blank_seed",  seed,   0);
                chk("blank_crstn", crst_n, 1);
            end
        end
        if (vr >= 0) begin
            k = 0;
            return;
        end
        if (pops) exp_cut = b;
        else if (unr && exp_ucnt < UMAX) exp_ucnt++;
        for (int i = 0; i < A; i++) begin
            h = 1'b0; v = 1'b0; rv = take; rb = b;
            tick();
            chk("act_take", take, 0);
            chk("act_und",  und,  (i == 0 && unr));
            if (i == 0) begin
                chk("ls_cut",  cut,     exp_cut);
                chk("ls_cutv", cut_vld, 1);
                chk("ls_lidx", lidx,    k % (1 << LW));
                chk("ls_ucnt", ucnt,    exp_ucnt);
            end
        end
        k++;
    endtask

    initial begin
        bit ended;
        int nl, bl, d, vr;

        // Reset with H=V=1: all outputs idle, no pulses after release.
        rst_n = 1'b0; h = 1'b1; v = 1'b1; rv = 1'b0; rb = '0;
        repeat (3) tick();
        chk_rst("rst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_rst("rst_rel");
        end

        // V fall without pulses, then V rise produces the seed/reset pulse.
        h = 1'b1; v = 1'b0;
        tick(); tick();
        chk("vf0_seed", seed, 0);
        field_gap(3, 1);

        // Directed lines: A5, 3C, underrun, then lines past the fetch limit.
        run_line(4, 5, 1, 8'hA5, -1);
        run_line(4, 5, 2, 8'h3C, -1);
        run_line(4, 5, 9, 8'h5A, -1);
        run_line(4, 5, 0, 8'h77, -1);
        run_line(3, 4, 1, 8'h88, -1);

        // V rise coincident with H rise; V rise during FETCH before the byte arrives.
        field_gap(3, 1);
        run_line(5, 4, 0, 8'h11, 0);
        field_gap(3, 0);
        run_line(6, 3, 4, 8'h22, 2);
        field_gap(2, 0);

        // Underrun counter saturation.
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < MAXF; j++) run_line(3, 2, 7, 8'($urandom), -1);
            field_gap(2, 1);
        end

        // line_index wrap within one long field.
        for (int j = 0; j < 18; j++) run_line(3, 2, 1, 8'(j * 7 + 1), -1);
        field_gap(2, 1);

        // Randomized fields.
        for (int f = 0; f < 8; f++) begin
            nl = $urandom_range(1, 18);
            ended = 1'b0;
            for (int j = 0; j < nl; j++) begin
                bl = $urandom_range(2, 6);
                d  = $urandom_range(0, bl + 1);
                vr = (j == nl - 1 && $urandom_range(0, 2) == 0) ? $urandom_range(0, bl - 1) : -1;
                run_line(bl, $urandom_range(2, 5), d, 8'($urandom), vr);
                if (vr >= 0) ended = 1'b1;
            end
            field_gap($urandom_range(1, 4), !ended);
        end

        // Asynchronous reset while in FETCH.
        h = 1'b1; v = 1'b0; rv = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1 chk_rst("arst");
        exp_cut = '0; exp_ucnt = 0; k = 0;
        h = 1'b1; v = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_rst("arst_rel");
        end
        h = 1'b1; v = 1'b0;
        tick(); tick();
        field_gap(2, 1);
        run_line(4, 3, 1, 8'hC3, -1);
        run_line(4, 3, 8, 8'h99, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
